// File: rtl/demux_1_n_stream_if.sv
// Stream bus for the 1-to-N demultiplexer: one input stream with a destination
// select, N independent output streams, and status.
interface demux_1_n_stream_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int SELW = $clog2(N);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic [SELW-1:0]      in_sel;
    logic                 in_bcast;
    logic [N-1:0]         out_valid;
    logic [N-1:0]         out_ready;
    logic [N*WIDTH-1:0]   out_data;
    logic [7:0]           drop_cnt;
    logic                 busy;

    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data, drop_cnt, busy
    );

    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data, drop_cnt, busy
    );
endinterface

// File: rtl/demux_1_n_stream.sv
// 1-to-N stream demultiplexer with unicast/broadcast routing, one register slot
// per output channel, and a saturating count of words dropped for bad selects.
module demux_1_n_stream #(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    demux_1_n_stream_if.slave  bus
);
    localparam int SELW  = $clog2(N);
    localparam int SLOTS = 1 << SELW;
    localparam logic [SELW:0] N_EXT = (SELW + 1)'(N);

    logic [N-1:0]     valid_q;
    logic [WIDTH-1:0] data_q [N];
    logic [7:0]       drop_q;

    logic [N-1:0]     free;
    logic [SLOTS-1:0] free_pad;
    logic             sel_ok;
    logic             ready;
    logic             accept;
    logic             drop;
    logic [N-1:0]     load;

    // A slot is free if empty or being popped this cycle, allowing same-cycle refill.
    assign free = ~valid_q | bus.out_ready;

    // Unused select codes read as free, so out-of-range words are always accepted.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        free_pad          = '1;
        free_pad[N-1:0]   = free;
    end

    assign sel_ok = {1'b0, bus.in_sel} < N_EXT;
    assign ready  = bus.in_bcast ? &free : free_pad[bus.in_sel];
    assign accept = bus.in_valid & ready;
    assign drop   = accept & ~bus.in_bcast & ~sel_ok;

    always_comb begin
        load = '0;
        for (int k = 0; k < N; k++) begin
            load[k] = accept && (bus.in_bcast || bus.in_sel == SELW'(k));
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_chan
        // NOTE: the data flops take the async reset too, because out_data must read zero in reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q[k] <= 1'b0;
                data_q[k]  <= '0;
            end else begin
                // NOTE: sequential state uses non-blocking assignments only.
                valid_q[k] <= load[k] | (valid_q[k] & ~bus.out_ready[k]);
                if (load[k]) begin
                    data_q[k] <= bus.in_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else if (drop && drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    always_comb begin
        bus.out_data = '0;
        for (int k = 0; k < N; k++) begin
            bus.out_data[k*WIDTH +: WIDTH] = data_q[k];
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid_q;
    assign bus.drop_cnt  = drop_q;
    assign bus.busy      = |valid_q;
endmodule

// File: tb/tb_demux_1_n_stream.sv
// Self-checking bench: directed cases on N=4 and N=5 instances, then a random
// scoreboard stress on an N=16, WIDTH=32 instance.
module tb_demux_1_n_stream;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    demux_1_n_stream_if #(.WIDTH(8),  .N(4))  bus4 ();
    demux_1_n_stream_if #(.WIDTH(8),  .N(5))  bus5 ();
    demux_1_n_stream_if #(.WIDTH(32), .N(16)) bus16 ();

    demux_1_n_stream #(.WIDTH(8),  .N(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    demux_1_n_stream #(.WIDTH(8),  .N(5))  dut5  (.clk(clk), .rst_n(rst_n), .bus(bus5.slave));
    demux_1_n_stream #(.WIDTH(32), .N(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Per-channel expected words for the N=16 instance; size is 0 or 1 while in flight.
    logic [31:0] exp_q [16][$];

    task automatic stress_cycle(input bit drain);
        logic [15:0] free_m;
        logic [15:0] held_m;
        logic        exp_ready;
        @(negedge clk);
        if (drain) begin
            bus16.in_valid  = 1'b0;
            bus16.out_ready = '1;
        end else begin
            bus16.in_valid  = ($urandom_range(0, 3) != 0);
            bus16.out_ready = 16'($urandom);
            bus16.in_sel    = 4'($urandom_range(0, 15));
            bus16.in_bcast  = ($urandom_range(0, 7) == 0);
            bus16.in_data   = $urandom;
        end
        #1;
        for (int k = 0; k < 16; k++) begin
            held_m[k] = (exp_q[k].size() != 0);
            free_m[k] = !held_m[k] || bus16.out_ready[k];
        end
        exp_ready = bus16.in_bcast ? &free_m : free_m[bus16.in_sel];
        check("sb_ready", bus16.in_ready, exp_ready);
        check("sb_valid", bus16.out_valid, held_m);
        for (int k = 0; k < 16; k++) begin
            if (held_m[k]) begin
                check("sb_data", bus16.out_data[k*32 +: 32], exp_q[k][0]);
                if (bus16.out_valid[k] && bus16.out_ready[k]) begin
                    void'(exp_q[k].pop_front());
                end
            end
        end
        if (bus16.in_valid && bus16.in_ready) begin
            for (int k = 0; k < 16; k++) begin
                if (bus16.in_bcast || bus16.in_sel == 4'(k)) begin
                    exp_q[k].push_back(bus16.in_data);
                end
            end
        end
    endtask

    initial begin
        int total;
        rst_n = 1'b0;
        bus4.in_valid = 1'b1; bus4.in_sel = 2'd1; bus4.in_data = 8'h99; bus4.in_bcast = 1'b0;
        bus4.out_ready = '1;
        bus5.in_valid = 1'b0; bus5.in_sel = '0; bus5.in_data = '0; bus5.in_bcast = 1'b0;
        bus5.out_ready = '1;
        bus16.in_valid = 1'b0; bus16.in_sel = '0; bus16.in_data = '0; bus16.in_bcast = 1'b0;
        bus16.out_ready = '1;

        // Reset state, with an offered word that must have no effect.
        @(negedge clk);
        #1;
        check("rst_valid", bus4.out_valid, 4'b0000);
        check("rst_data",  bus4.out_data, 32'h0);
        check("rst_drop",  bus4.drop_cnt, 8'h00);
        check("rst_busy",  bus4.busy, 1'b0);
        bus4.in_valid = 1'b0;
        rst_n = 1'b1;

        // Unicast to channel 2 with one-cycle latency, then a pop.
        @(negedge clk);
        bus4.in_sel = 2'd2; bus4.in_data = 8'hA5; bus4.in_valid = 1'b1;
        #1 check("uni_ready", bus4.in_ready, 1'b1);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        #1;
        check("uni_valid", bus4.out_valid, 4'b0100);
        check("uni_data",  bus4.out_data[23:16], 8'hA5);
        check("uni_busy",  bus4.busy, 1'b1);
        @(negedge clk);
        #1;
        check("pop_valid", bus4.out_valid, 4'b0000);
        check("pop_data",  bus4.out_data[23:16], 8'hA5);

        // Backpressure on channel 1, then release with no bubble.
        bus4.out_ready = 4'b1101;
        bus4.in_sel = 2'd1; bus4.in_data = 8'h11; bus4.in_valid = 1'b1;
        @(negedge clk);
        bus4.in_data = 8'h22;
        #1;
        check("bp_ready", bus4.in_ready, 1'b0);
        check("bp_valid", bus4.out_valid[1], 1'b1);
        check("bp_data",  bus4.out_data[15:8], 8'h11);
        @(negedge clk);
        #1;
        check("bp_hold",   bus4.out_data[15:8], 8'h11);
        check("bp_ready2", bus4.in_ready, 1'b0);
        bus4.out_ready = 4'b1111;
        #1 check("bp_release", bus4.in_ready, 1'b1);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        #1;
        check("nobubble_valid", bus4.out_valid[1], 1'b1);
        check("nobubble_data",  bus4.out_data[15:8], 8'h22);
        @(negedge clk);
        #1 check("bp_drain", bus4.out_valid, 4'b0000);

        // Broadcast blocked by a full channel 3, then released.
        bus4.out_ready = 4'b0111;
        bus4.in_sel = 2'd3; bus4.in_data = 8'h77; bus4.in_valid = 1'b1;
        @(negedge clk);
        bus4.in_bcast = 1'b1; bus4.in_data = 8'h3C;
        #1 check("bc_blocked", bus4.in_ready, 1'b0);
        @(negedge clk);
        #1;
        check("bc_wait_valid", bus4.out_valid, 4'b1000);
        check("bc_wait_data",  bus4.out_data[31:24], 8'h77);
        bus4.out_ready = 4'b1111;
        #1 check("bc_ready", bus4.in_ready, 1'b1);
        @(negedge clk);
        bus4.in_valid = 1'b0; bus4.in_bcast = 1'b0;
        #1;
        check("bc_valid", bus4.out_valid, 4'b1111);
        check("bc_data",  bus4.out_data, 32'h3C3C3C3C);

        // N=5: seven drops and loads on channels 0,1,3, then an async reset.
        bus5.out_ready = '0;
        bus5.in_sel = 3'd6; bus5.in_data = 8'hD0; bus5.in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            #1 check("drop_ready", bus5.in_ready, 1'b1);
            @(negedge clk);
        end
        bus5.in_sel = 3'd0; bus5.in_data = 8'hA0; @(negedge clk);
        bus5.in_sel = 3'd1; bus5.in_data = 8'hA1; @(negedge clk);
        bus5.in_sel = 3'd3; bus5.in_data = 8'hA3; @(negedge clk);
        bus5.in_valid = 1'b0;
        #1;
        check("pre_rst_valid", bus5.out_valid, 5'b01011);
        check("pre_rst_drop",  bus5.drop_cnt, 8'd7);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid", bus5.out_valid, 5'b00000);
        check("arst_data",  bus5.out_data, 40'h0);
        check("arst_drop",  bus5.drop_cnt, 8'h00);
        check("arst_busy",  bus5.busy, 1'b0);
        bus5.out_ready = '0;
        bus5.in_sel = 3'd2; bus5.in_data = 8'hEE; bus5.in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 check("rst_accept_ignored", bus5.out_valid, 5'b00000);
        bus5.out_ready = '1;
        bus5.in_sel = 3'd0; bus5.in_data = 8'h5A;
        rst_n = 1'b1;
        @(negedge clk);
        bus5.in_valid = 1'b0;
        #1;
        check("post_rst_valid", bus5.out_valid, 5'b00001);
        check("post_rst_data",  bus5.out_data[7:0], 8'h5A);
        check("post_rst_drop",  bus5.drop_cnt, 8'h00);

        // Hold channel 2, then 300 out-of-range words to saturate the drop count.
        bus5.out_ready = 5'b11011;
        bus5.in_sel = 3'd2; bus5.in_data = 8'h42; bus5.in_valid = 1'b1;
        @(negedge clk);
        bus5.in_sel = 3'd6;
        for (int i = 0; i < 300; i++) begin
            bus5.in_data = 8'($urandom);
            #1;
            check("sat_ready", bus5.in_ready, 1'b1);
            check("sat_valid", bus5.out_valid, 5'b00100);
            @(negedge clk);
        end
        bus5.in_valid = 1'b0;
        #1;
        check("sat_drop", bus5.drop_cnt, 8'hFF);
        check("sat_hold", bus5.out_data[23:16], 8'h42);

        // Random stress with per-channel scoreboard, then drain.
        for (int i = 0; i < 3000; i++) begin
            stress_cycle(1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            stress_cycle(1'b1);
        end
        total = 0;
        for (int k = 0; k < 16; k++) begin
            total += exp_q[k].size();
        end
        check("sb_empty", 64'(total), 64'd0);
        check("sb_busy",  bus16.busy, 1'b0);
        check("sb_drop",  bus16.drop_cnt, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/demux_1_n_stream.md
DEMUX_1_N_STREAM -- requirements
Module: demux_1_n_stream

Interface
REQ-001 Parameter WIDTH, default 8: data width per channel, legal range 1..64.
REQ-002 Parameter N, default 4: output channel count, legal range 2..16.
REQ-003 Parameter SELW, default $clog2(N): select width, derived and not overridden.
REQ-004 Port clk, input, 1: single clock, all state updates on the rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port in_valid, input, 1: input word present.
REQ-007 Port in_ready, output, 1: input word accepted this cycle when high together with in_valid.
REQ-008 Port in_data, input, WIDTH: input word.
REQ-009 Port in_sel, input, SELW: destination channel index.
REQ-010 Port in_bcast, input, 1: broadcast mode; when high, in_sel is ignored.
REQ-011 Port out_valid, output, N: per-channel word held.
REQ-012 Port out_ready, input, N: per-channel consumer ready.
REQ-013 Port out_data, output, N*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-014 Port drop_cnt, output, 8: count of words dropped for an out-of-range select.
REQ-015 Port busy, output, 1: OR of all out_valid bits.

Function
REQ-016 Each channel SHALL hold exactly one output register (data plus valid); out_data and out_valid SHALL come directly from flops.
REQ-017 A channel k SHALL be free when out_valid[k]=0 or out_ready[k]=1 in the same cycle (a pop frees the slot for a same-cycle refill).
REQ-018 Unicast (in_bcast=0, in_sel<N): in_ready SHALL equal "channel in_sel is free".
REQ-019 Broadcast (in_bcast=1): in_ready SHALL equal "all N channels are free".
REQ-020 Out-of-range select (in_bcast=0, in_sel>=N): in_ready SHALL be 1; the word is accepted and discarded, and no out_valid bit changes because of it.
REQ-021 On acceptance in unicast mode, the next edge SHALL load in_data into channel in_sel and set its out_valid; latency is one cycle from the accept edge to out_valid.
REQ-022 On acceptance in broadcast mode, the next edge SHALL load in_data into every channel and set all out_valid bits.
REQ-023 Pop: out_valid[k]=1 with out_ready[k]=1 and no load to k SHALL clear out_valid[k] on the next edge; out_data[k] keeps its last value.
REQ-024 Simultaneous pop and load on the same channel SHALL leave out_valid[k]=1 with the new data; there is no bubble.
REQ-025 Channels that are neither loaded nor popped SHALL hold both data and valid.
REQ-026 out_data[k] SHALL NOT change while out_valid[k]=1 and out_ready[k]=0.
REQ-027 Pops on different channels SHALL be independent, and any number of pops may occur in the same cycle.
REQ-028 drop_cnt SHALL increment by 1 per out-of-range accept and saturate at 255.
REQ-029 in_ready SHALL be combinational from in_valid-independent state and inputs only (in_sel, in_bcast, out_valid, out_ready); it SHALL have no dependency on in_valid.
REQ-030 Behaviour with in_valid=0 SHALL be independent of in_data, in_sel and in_bcast.

Reset
REQ-031 While rst_n=0, out_valid SHALL be all 0, out_data all 0, drop_cnt 0 and busy 0, asynchronously and without waiting for a clock edge.
REQ-032 Reset asserted mid-transfer SHALL discard all held words with no partial state retained; the first accept after rst_n rises is treated as the first word.
REQ-033 in_ready MAY be high during reset; accepts during reset SHALL have no effect.

Verification
REQ-034 N=4, WIDTH=8, all out_ready=1: unicast in_sel=2, in_data=0xA5 accepted at edge t -> out_valid=0100, out_data[2]=0xA5 after edge t; out_valid=0000 after edge t+1 if there is no new input.
REQ-035 Backpressure: out_ready[1]=0, load 0x11 then offer 0x22 to channel 1 -> in_ready=0 and out_data[1] stays 0x11; raise out_ready[1] -> 0x22 accepted in that cycle and out_valid[1] stays 1 with no bubble.
REQ-036 Broadcast 0x3C with channel 3 full and not ready -> in_ready=0; release channel 3 -> all four channels hold 0x3C and out_valid=1111.
REQ-037 N=5, SELW=3: in_sel=6 pushed 300 times -> in_ready=1 throughout, out_valid unchanged, drop_cnt=255.
REQ-038 Drop rst_n asynchronously between clock edges with out_valid=1011 and drop_cnt=7 -> all outputs 0 immediately; after release a unicast to channel 0 appears one cycle after its accept.
REQ-039 Random stress, N=16, WIDTH=32, random valid/ready/sel/bcast -> per-channel scoreboard shows in-order delivery with no loss or duplication, and the drop count matches the reference model.
